// File: rtl/mips_pkg.sv
// Shared MIPS definitions: fetch FSM encoding, opcodes and PC arithmetic helpers.
package mips_pkg;

    localparam int PC_W = 32;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RESOLVE = 2'd2
    } fetch_state_t;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2b;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_J     = 6'h02;

    // Offset is a sign-extended word count; the shift drops the top bits and the sum wraps.
    function automatic pc_t branch_target(input pc_t base, input logic [31:0] word_offset);
        return base + (word_offset << 2);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-unit bus: instruction-memory port, decode issue handshake and resolve feedback.
// master = fetch_sequencer side, slave = memory/decode/controller side.
interface fetch_sequencer_if;
    import mips_pkg::*;

    logic        imem_req;
    pc_t         imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    logic [31:0] instr;
    pc_t         instr_pc_plus4;
    logic        instr_valid;
    logic        instr_ready;

    logic        resolve_valid;
    logic        jump;
    logic        branch;
    logic        zero;
    logic [31:0] branch_offset;
    logic [25:0] jump_target;

    logic [31:0] retired_count;

    modport master (
        output imem_req, imem_addr, instr, instr_pc_plus4, instr_valid, retired_count,
        input  imem_ack, imem_rdata, instr_ready, resolve_valid, jump, branch, zero,
               branch_offset, jump_target
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc_plus4, instr_valid, retired_count,
        output imem_ack, imem_rdata, instr_ready, resolve_valid, jump, branch, zero,
               branch_offset, jump_target
    );

endinterface

// File: rtl/fetch_sequencer_next_pc_calc.sv
// Next-PC mux: jump > taken branch > sequential; purely combinational, no backpressure.
module next_pc_calc
    import mips_pkg::*;
(
    input  pc_t         pc_plus4,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] branch_offset,
    input  logic [25:0] jump_target,
    output pc_t         next_pc
);

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], jump_target, 2'b00};
        end else if (branch && zero) begin
            next_pc = branch_target(pc_plus4, branch_offset);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Non-pipelined fetch/PC sequencer; min 3 cycles/instr (fetch, issue, resolve).
// Holds imem request until ack and instr until instr_ready; waits indefinitely for resolve.
module fetch_sequencer
    import mips_pkg::*;
#(
    parameter pc_t         RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
);

    fetch_state_t state;
    fetch_state_t state_nxt;

    pc_t         pc;
    pc_t         pc_plus4;
    pc_t         next_pc;
    logic [31:0] instr;
    logic [31:0] retired_count;
    logic        armed;

    logic        imem_req;
    logic        instr_valid;
    logic        fetch_done;
    logic        issue_done;
    logic        resolve_done;

    // armed keeps the request low for the first cycle out of reset, so an ack
    // still in flight from before reset cannot be mistaken for a fresh fetch.
    assign fetch_done   = imem_req && bus.imem_ack;
    assign issue_done   = instr_valid && bus.instr_ready;
    assign resolve_done = (state == ST_RESOLVE) && bus.resolve_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH:   if (fetch_done)   state_nxt = ST_ISSUE;
            ST_ISSUE:   if (issue_done)   state_nxt = ST_RESOLVE;
            ST_RESOLVE: if (resolve_done) state_nxt = ST_FETCH;
            default:                      state_nxt = ST_FETCH;
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            ST_FETCH: imem_req    = armed;
            ST_ISSUE: instr_valid = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_PC;
            pc_plus4      <= '0;
            instr         <= '0;
            retired_count <= '0;
            armed         <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (fetch_done) begin
                instr    <= bus.imem_rdata;
                pc_plus4 <= pc + pc_t'(PC_STEP);
            end
            if (resolve_done) begin
                pc            <= next_pc;
                retired_count <= retired_count + 32'd1;
            end
        end
    end

    next_pc_calc u_next_pc (
        .pc_plus4      (pc_plus4),
        .jump          (bus.jump),
        .branch        (bus.branch),
        .zero          (bus.zero),
        .branch_offset (bus.branch_offset),
        .jump_target   (bus.jump_target),
        .next_pc       (next_pc)
    );

    assign bus.imem_req       = imem_req;
    assign bus.imem_addr      = {pc[31:2], 2'b00};
    assign bus.instr          = instr;
    assign bus.instr_pc_plus4 = pc_plus4;
    assign bus.instr_valid    = instr_valid;
    assign bus.retired_count  = retired_count;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch and PC-sequencing unit for the MIPS core. It fetches instructions from instruction memory and presents each one to the decode/control stage.
- It consumes the jump/branch decisions that the main controller and ALU produce for that instruction, then computes the next PC.
- Non-pipelined: at most one instruction in flight. It sits between the instruction-memory port and the opcode decoder.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  fetch address; bits [1:0] always 0
- imem_ack  input  1  memory returns data this cycle; ignored unless imem_req=1
- imem_rdata  input  32  instruction word, valid when imem_ack=1
- instr  output  32  fetched instruction to decode (opcode = instr[31:26])
- instr_pc_plus4  output  32  PC of instr + PC_STEP
- instr_valid  output  1  instr/instr_pc_plus4 valid
- instr_ready  input  1  decode accepts the instruction
- resolve_valid  input  1  decode/control has resolved the accepted instruction
- jump  input  1  controller jump; sampled with resolve_valid
- branch  input  1  controller branch; sampled with resolve_valid
- zero  input  1  ALU zero flag; sampled with resolve_valid
- branch_offset  input  32  sign-extended immediate (word offset)
- jump_target  input  26  instr[25:0] of a J-type instruction
- retired_count  output  32  number of resolved instructions

Behaviour:
- Reset, sampled on clk rising edge:
  - pc=RESET_PC; state=FETCH.
  - imem_req=0, instr_valid=0, instr=0, instr_pc_plus4=0, retired_count=0.
  - Reset asserted in any state aborts the in-flight fetch or issue; a late imem_ack arriving after reset is ignored.
- States: FETCH, ISSUE, RESOLVE (2-bit encoding).
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until ack.
  - On imem_ack=1: latch instr=imem_rdata and instr_pc_plus4=pc+PC_STEP, then go to ISSUE.
  - Ack may arrive in the first request cycle (zero wait states).
  - The first imem_req=1 occurs in the cycle after reset deasserts.
- ISSUE:
  - imem_req=0, instr_valid=1; instr is held constant while valid.
  - On instr_valid && instr_ready: go to RESOLVE and drop instr_valid the next cycle.
  - resolve_valid is ignored in ISSUE.
- RESOLVE:
  - instr_valid=0, imem_req=0. Wait for resolve_valid (earliest: the cycle after the handshake).
  - On resolve_valid: pc <= next_pc, retired_count++, go to FETCH.
- next_pc priority:
  - jump=1: {instr_pc_plus4[31:28], jump_target, 2'b00}.
  - else branch=1 && zero=1: instr_pc_plus4 + (branch_offset << 2), modulo 2^32.
  - else: instr_pc_plus4.
- jump and branch both 1 is illegal from the controller; jump wins.
- X on jump/branch/zero outside resolve_valid has no effect.
- Arithmetic: all PC sums are 32-bit and wrap silently. pc=32'hFFFF_FFFC gives pc+4=0.
- retired_count wraps from 32'hFFFF_FFFF to 0.
- Latency per instruction: 1 + memory wait + 1 + decode wait + 1 cycles. Minimum is 3 cycles per instruction with zero-wait memory, ready=1, and resolve in the cycle after the handshake.

Decomposition:
- Shared package mips_pkg:
  - state encoding constants ST_FETCH/ST_ISSUE/ST_RESOLVE.
  - OPC_RTYPE/OPC_LW/OPC_SW/OPC_BEQ/OPC_J opcode constants, shared with the controller.
  - PC width constant (32).
- One natural sub-module, next_pc_calc: combinational jump/branch/sequential target mux and adders. Keeps the FSM file free of arithmetic and lets the bench test targets in isolation.

Test Plan:
- Reset then zero-wait memory, ready=1, resolve with jump=branch=0 -> imem_addr sequence 0x0,0x4,0x8, 3 cycles apart; retired_count=3 after three resolves.
- At pc=0x40, resolve branch=1, zero=1, branch_offset=32'hFFFF_FFFE -> next imem_addr=0x3C. Same with zero=0 -> 0x44.
- At pc=0x9000_0010, resolve jump=1, jump_target=26'h000_0100 -> next imem_addr=0x9000_0400.
- imem_ack delayed 3 cycles, and instr_ready held low 2 cycles after instr_valid -> imem_addr stable throughout; instr unchanged while valid; exactly one handshake.
- Reset asserted in ISSUE with instr_valid=1, and again in FETCH while awaiting ack -> next cycle instr_valid=0, imem_req=0, retired_count=0; fetch restarts at RESET_PC; a late ack is ignored.
- pc=32'hFFFF_FFFC, plain resolve -> next imem_addr=0x0. resolve_valid pulsed during ISSUE -> ignored, pc unchanged.
